// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the RAM arbiter slice.
//   MEMORYSIZE  RAM size in bytes, shared with the RAM model
//   ADDR_W_DEF  default word-address width, log2(MEMORYSIZE/4)
//   state_t     arbiter FSM encoding (IDLE/ACCESS/RESP)
//   GNT_I/GNT_D grant encoding for fetch / data port
//   out_of_range() address range test against a word-address width
package mem_arbiter_pkg;

  localparam int unsigned MEMORYSIZE = 1024;
  localparam int unsigned ADDR_W_DEF = $clog2(MEMORYSIZE / 4);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  // Any byte-address bit above the RAM's word range marks the access out of range.
  function automatic logic out_of_range(input logic [31:0] addr, input int unsigned aw);
    return (addr >> (aw + 2)) != '0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way grant between fetch and data requesters.
//   i_valid, d_valid  request lines
//   last_grant        previous grant (GNT_I/GNT_D)
//   req               any request pending
//   grant             selected port (GNT_I/GNT_D)
//   PRIO_MODE         0 = alternate on contention, 1 = data wins contention
module rr_arb2
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic i_valid,
  input  logic d_valid,
  input  logic last_grant,
  output logic req,
  output logic grant
);

  always_comb begin
    req   = i_valid | d_valid;
    grant = GNT_I;
    if (i_valid && d_valid) begin
      grant = (PRIO_MODE != 0) ? GNT_D : ~last_grant;
    end else if (d_valid) begin
      grant = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port RAM between instruction fetch (read-only)
// and data (read/write) ports. One access every three cycles:
// IDLE (grant, load ram_*) -> ACCESS (RAM samples) -> RESP (ready pulse).
//   clock, resetn             clock, synchronous active-low reset
//   i_valid/i_addr            fetch request; i_ready/i_rdata/i_err response
//   d_valid/d_addr/d_wdata/d_wstrb  data request; d_ready/d_rdata/d_err response
//   ram_address/byteena/data/rden/wren  registered RAM controls
//   ram_q                     RAM read data, valid the cycle after ACCESS
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_valid,
  input  logic [31:0]       i_addr,
  output logic              i_ready,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_valid,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteena,
  output logic [31:0]       ram_data,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [31:0]       ram_q
);

  state_t      state;
  logic        last_grant;
  logic        gnt;
  logic        oor;
  logic        wr;
  logic        arb_req;
  logic        arb_gnt;
  logic [31:0] sel_addr;
  logic        sel_wr;
  logic        sel_oor;
  logic        unused_addr_lsb;

  rr_arb2 #(
    .PRIO_MODE(PRIO_MODE)
  ) u_arb (
    .i_valid   (i_valid),
    .d_valid   (d_valid),
    .last_grant(last_grant),
    .req       (arb_req),
    .grant     (arb_gnt)
  );

  always_comb begin
    sel_addr = (arb_gnt == GNT_D) ? d_addr : i_addr;
    sel_wr   = (arb_gnt == GNT_D) && (d_wstrb != '0);
    sel_oor  = out_of_range(sel_addr, ADDR_W);
  end

  assign unused_addr_lsb = ^sel_addr[1:0];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      last_grant  <= GNT_D;
      gnt         <= GNT_I;
      oor         <= 1'b0;
      wr          <= 1'b0;
      ram_address <= '0;
      ram_byteena <= '0;
      ram_data    <= '0;
      ram_rden    <= 1'b0;
      ram_wren    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_req) begin
            state       <= ST_ACCESS;
            gnt         <= arb_gnt;
            last_grant  <= arb_gnt;
            oor         <= sel_oor;
            wr          <= sel_wr;
            ram_address <= sel_addr[ADDR_W+1:2];
            ram_byteena <= sel_wr ? d_wstrb : 4'hF;
            ram_data    <= sel_wr ? d_wdata : '0;
            // Out-of-range accesses keep their timing but never touch the RAM.
            ram_rden    <= !sel_wr && !sel_oor;
            ram_wren    <= sel_wr && !sel_oor;
          end
        end
        ST_ACCESS: begin
          state       <= ST_RESP;
          ram_rden    <= 1'b0;
          ram_wren    <= 1'b0;
          ram_byteena <= '0;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Responses decode from state so a reset sampled in RESP still shows the pulse.
  always_comb begin
    i_ready = (state == ST_RESP) && (gnt == GNT_I);
    d_ready = (state == ST_RESP) && (gnt == GNT_D);
    i_err   = i_ready && oor;
    d_err   = d_ready && oor;
    i_rdata = (i_ready && !wr && !oor) ? ram_q : '0;
    d_rdata = (d_ready && !wr && !oor) ? ram_q : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned AW = 8;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic resetn;

  // instance 0: round-robin
  logic          i_valid, d_valid, i_ready, d_ready, i_err, d_err;
  logic [31:0]   i_addr, d_addr, d_wdata, i_rdata, d_rdata;
  logic [3:0]    d_wstrb;
  logic [AW-1:0] ram_address;
  logic [3:0]    ram_byteena;
  logic [31:0]   ram_data, ram_q;
  logic          ram_rden, ram_wren;

  // instance 1: data priority
  logic          p1_i_valid, p1_d_valid, p1_i_ready, p1_d_ready, p1_i_err, p1_d_err;
  logic [31:0]   p1_i_addr, p1_d_addr, p1_d_wdata, p1_i_rdata, p1_d_rdata;
  logic [3:0]    p1_d_wstrb;
  logic [AW-1:0] p1_ram_address;
  logic [3:0]    p1_ram_byteena;
  logic [31:0]   p1_ram_data, p1_ram_q;
  logic          p1_ram_rden, p1_ram_wren;

  logic [31:0] ram0 [0:255];
  logic [31:0] ram1 [0:255];
  logic [31:0] shadow [0:255];
  logic        poke_en;
  logic [7:0]  poke_addr;
  logic [31:0] poke_data;
  int          wren_cnt = 0;
  bit          mon_en = 0;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic lg;

  mem_arbiter #(.ADDR_W(AW), .PRIO_MODE(0)) dut0 (
    .clock(clock), .resetn(resetn),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .ram_address(ram_address), .ram_byteena(ram_byteena), .ram_data(ram_data),
    .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  mem_arbiter #(.ADDR_W(AW), .PRIO_MODE(1)) dut1 (
    .clock(clock), .resetn(resetn),
    .i_valid(p1_i_valid), .i_addr(p1_i_addr), .i_ready(p1_i_ready), .i_rdata(p1_i_rdata),
    .i_err(p1_i_err),
    .d_valid(p1_d_valid), .d_addr(p1_d_addr), .d_wdata(p1_d_wdata), .d_wstrb(p1_d_wstrb),
    .d_ready(p1_d_ready), .d_rdata(p1_d_rdata), .d_err(p1_d_err),
    .ram_address(p1_ram_address), .ram_byteena(p1_ram_byteena), .ram_data(p1_ram_data),
    .ram_rden(p1_ram_rden), .ram_wren(p1_ram_wren), .ram_q(p1_ram_q)
  );

  // RAM models: registered read, byte-enabled write, bench preload port.
  always @(posedge clock) begin
    if (poke_en) begin
      ram0[poke_addr] <= poke_data;
      ram1[poke_addr] <= poke_data;
    end
    if (ram_wren) begin
      wren_cnt <= wren_cnt + 1;
      for (int b = 0; b < 4; b++)
        if (ram_byteena[b]) ram0[ram_address][8*b +: 8] <= ram_data[8*b +: 8];
    end
    if (ram_rden) ram_q <= ram0[ram_address];
    if (p1_ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (p1_ram_byteena[b]) ram1[p1_ram_address][8*b +: 8] <= p1_ram_data[8*b +: 8];
    end
    if (p1_ram_rden) p1_ram_q <= ram1[p1_ram_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      check("one_ready", {31'b0, i_ready & d_ready}, 32'd0);
      check("rw_excl", {31'b0, ram_rden & ram_wren}, 32'd0);
      check("p1_one_ready", {31'b0, p1_i_ready & p1_d_ready}, 32'd0);
      check("p1_rw_excl", {31'b0, p1_ram_rden & p1_ram_wren}, 32'd0);
    end
  end

  function automatic logic tb_oor(input logic [31:0] a);
    return a[31:10] != 22'd0;
  endfunction

  task automatic poke(input int unsigned w, input logic [31:0] v);
    poke_en   = 1'b1;
    poke_addr = w[7:0];
    poke_data = v;
    shadow[w] = v;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  task automatic push_i(input logic [31:0] a);
    exp_t e;
    e.port = GNT_I;
    e.err  = tb_oor(a);
    e.data = e.err ? 32'd0 : shadow[a[9:2]];
    sb.push_back(e);
  endtask

  task automatic push_d(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    exp_t e;
    e.port = GNT_D;
    e.err  = tb_oor(a);
    if (!e.err && ws != 4'h0)
      for (int b = 0; b < 4; b++)
        if (ws[b]) shadow[a[9:2]][8*b +: 8] = wd[8*b +: 8];
    e.data = (e.err || ws != 4'h0) ? 32'd0 : shadow[a[9:2]];
    sb.push_back(e);
  endtask

  task automatic drive_i(input logic [31:0] a);
    push_i(a);
    i_addr  = a;
    i_valid = 1'b1;
  endtask

  task automatic drive_d(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    push_d(a, wd, ws);
    d_addr  = a;
    d_wdata = wd;
    d_wstrb = ws;
    d_valid = 1'b1;
  endtask

  // Wait (bounded) for the next ready on an instance, compare against the
  // scoreboard head and release the served requester.
  task automatic wait_resp(input int inst, input string tag, input int exp_lat);
    exp_t e;
    logic ri, rd, port, err;
    logic [31:0] data;
    int n;
    bit got;
    n = 0;
    got = 0;
    ri = 0; rd = 0; err = 0; data = '0;
    while (!got && n < 10) begin
      @(negedge clock);
      n++;
      if (inst == 0) begin
        ri = i_ready; rd = d_ready;
        err = rd ? d_err : i_err;
        data = rd ? d_rdata : i_rdata;
      end else begin
        ri = p1_i_ready; rd = p1_d_ready;
        err = rd ? p1_d_err : p1_i_err;
        data = rd ? p1_d_rdata : p1_i_rdata;
      end
      got = ri | rd;
    end
    check({tag, "_ready"}, {31'b0, got}, 32'd1);
    if (!got) return;
    check({tag, "_sb"}, {31'b0, sb.size() != 0}, 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    port = rd ? GNT_D : GNT_I;
    check({tag, "_port"}, {31'b0, port}, {31'b0, e.port});
    check({tag, "_rdata"}, data, e.data);
    check({tag, "_err"}, {31'b0, err}, {31'b0, e.err});
    if (exp_lat > 0) check({tag, "_lat"}, n, exp_lat);
    if (inst == 0) begin
      if (rd) d_valid = 1'b0; else i_valid = 1'b0;
    end else begin
      if (rd) p1_d_valid = 1'b0; else p1_i_valid = 1'b0;
    end
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_outs0", {31'b0, |{i_ready, i_err, d_ready, d_err, i_rdata, d_rdata,
                                 ram_address, ram_byteena, ram_data, ram_rden, ram_wren}}, 32'd0);
    check("rst_outs1", {31'b0, |{p1_i_ready, p1_d_ready, p1_ram_address, p1_ram_byteena,
                                 p1_ram_data, p1_ram_rden, p1_ram_wren}}, 32'd0);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    i_valid = 0; i_addr = '0; d_valid = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    p1_i_valid = 0; p1_i_addr = '0; p1_d_valid = 0; p1_d_addr = '0;
    p1_d_wdata = '0; p1_d_wstrb = '0;
    @(negedge clock);
    for (int unsigned w = 0; w < 256; w++) poke(w, $urandom);
    poke(5, 32'hDEADBEEF);
    poke(8, 32'h11223344);
    apply_reset();
    mon_en = 1;

    // 1. fetch read: rden only in cycle 1, data in cycle 2
    drive_i(32'h14);
    @(negedge clock);
    check("t1_rden_c1", {31'b0, ram_rden}, 32'd1);
    check("t1_addr_c1", {24'b0, ram_address}, 32'd5);
    check("t1_noready_c1", {31'b0, i_ready}, 32'd0);
    wait_resp(0, "t1", 1);
    check("t1_rden_c2", {31'b0, ram_rden}, 32'd0);
    check("t1_rdata_val", i_rdata, 32'hDEADBEEF);

    // 3a. contention after reset, round-robin: I, D, I
    apply_reset();
    drive_i(32'h14);
    drive_d(32'h20, 32'd0, 4'h0);
    push_i(32'h14);
    wait_resp(0, "t3a_1", 2);
    i_valid = 1'b1;
    wait_resp(0, "t3a_2", 3);
    d_valid = 1'b1;
    wait_resp(0, "t3a_3", 3);
    d_valid = 1'b0;
    i_valid = 1'b0;

    // 3b. data priority with both requesting continuously: D every time
    @(negedge clock);
    p1_i_addr = 32'h14; p1_d_addr = 32'h20; p1_d_wstrb = 4'h0;
    p1_i_valid = 1'b1; p1_d_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_d(32'h20, 32'd0, 4'h0);
      wait_resp(1, "t3b", (k == 0) ? 2 : 3);
      p1_d_valid = 1'b1;
    end
    p1_d_valid = 1'b0;
    p1_i_valid = 1'b0;

    // 2. byte write then readback
    @(negedge clock);
    drive_d(32'h20, 32'h0000AB00, 4'b0010);
    wait_resp(0, "t2_wr", 2);
    @(negedge clock);
    drive_d(32'h20, 32'd0, 4'h0);
    wait_resp(0, "t2_rd", 2);
    check("t2_mem", ram0[8], 32'h1122AB44);

    // 4. out-of-range write
    begin
      int snap;
      snap = wren_cnt;
      @(negedge clock);
      drive_d(32'h400, 32'h55555555, 4'hF);
      wait_resp(0, "t4", 2);
      @(negedge clock);
      check("t4_wren_cnt", wren_cnt - snap, 32'd0);
      check("t4_mem", ram0[0], shadow[0]);
    end

    // 5. reset sampled in ACCESS: write commits, no ready
    drive_d(32'hC, 32'hCAFEF00D, 4'hF);
    sb.delete();
    @(negedge clock);
    check("t5_wren", {31'b0, ram_wren}, 32'd1);
    resetn = 1'b0;
    @(negedge clock);
    check("t5_noready", {31'b0, d_ready}, 32'd0);
    check("t5_outs", {31'b0, |{i_ready, i_err, d_ready, d_err, i_rdata, d_rdata,
                               ram_address, ram_byteena, ram_data, ram_rden, ram_wren}}, 32'd0);
    check("t5_mem", ram0[3], 32'hCAFEF00D);
    shadow[3] = 32'hCAFEF00D;
    d_valid = 1'b0;
    resetn = 1'b1;
    @(negedge clock);
    check("t5_noready2", {31'b0, d_ready}, 32'd0);
    drive_d(32'hC, 32'd0, 4'h0);
    wait_resp(0, "t5_rd", 2);

    // reset sampled in RESP: pulse still visible that cycle
    @(negedge clock);
    i_addr = 32'h14;
    i_valid = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("t5b_ready", {31'b0, i_ready}, 32'd1);
    check("t5b_rdata", i_rdata, shadow[5]);
    resetn = 1'b0;
    i_valid = 1'b0;
    @(negedge clock);
    check("t5b_cleared", {31'b0, |{i_ready, d_ready, ram_rden, ram_wren, ram_byteena}}, 32'd0);
    resetn = 1'b1;
    lg = GNT_D;

    // 6. random traffic
    for (int k = 0; k < 40; k++) begin
      int mode;
      logic [31:0] ia, da, wd;
      logic [3:0] ws;
      mode = $urandom_range(0, 2);
      ia = 32'($urandom_range(0, 15)) << 2;
      da = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 7) == 0) da = da | 32'h1000;
      wd = $urandom;
      ws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      @(negedge clock);
      d_addr = da; d_wdata = wd; d_wstrb = ws; i_addr = ia;
      if (mode == 0) begin
        push_i(ia); i_valid = 1'b1;
        wait_resp(0, "rnd_i", 2);
        lg = GNT_I;
      end else if (mode == 1) begin
        push_d(da, wd, ws); d_valid = 1'b1;
        wait_resp(0, "rnd_d", 2);
        lg = GNT_D;
      end else begin
        if (lg == GNT_D) begin
          push_i(ia); push_d(da, wd, ws);
        end else begin
          push_d(da, wd, ws); push_i(ia);
        end
        i_valid = 1'b1; d_valid = 1'b1;
        wait_resp(0, "rnd_b1", 2);
        wait_resp(0, "rnd_b2", 3);
      end
    end
    @(negedge clock);
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
